// File: rtl/mem_decode.sv
`default_nettype none
// ============================================================================
// mem_decode : 65xx bus address decoder, chip selects, RAM write strobe and
//              CPU-writable bank register, all in the fast clk domain.
// Revision   : 1.0
// ============================================================================
module mem_decode #(
   parameter int                       ADDR_W      = 16,
   parameter int                       NUM_CS      = 4,
   parameter logic [NUM_CS*ADDR_W-1:0] REGION_BASE = {16'h8000, 16'hD000, 16'hD400, 16'h0000},
   parameter logic [NUM_CS*ADDR_W-1:0] REGION_MASK = {16'h8000, 16'hFC00, 16'hFC00, 16'h8000},
   parameter int                       RAM_IDX     = 0,
   parameter logic [ADDR_W-1:0]        BANK_ADDR   = 16'hFF00,
   parameter int                       BANK_W      = 4,
   parameter int                       WE_CYCLES   = 2,
   parameter int                       SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_clk,
   input  logic              cpu_rwb,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        data_in,
   output logic [NUM_CS-1:0] cs_n,
   output logic              ram_we_n,
   output logic              bank_oe_n,
   output logic [BANK_W-1:0] bank
);

   localparam int               CNT_W    = $clog2(WE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] phi_sync;
   logic [SYNC_STAGES-1:0] rwb_sync;
   logic                   phi_d;
   logic                   phi_s;
   logic                   rwb_s;
   logic                   rise;
   logic                   fall;

   logic [NUM_CS-1:0]      hits;
   logic [NUM_CS-1:0]      sel;
   logic                   is_bank;
   logic                   bank_wr_pend;
   logic [CNT_W-1:0]       we_cnt;
   logic                   unused_data;

   // Reset to 1 so a phi2 phase already high at release never looks like a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phi_sync <= '1;
         rwb_sync <= '1;
         phi_d    <= 1'b1;
      end else begin
         phi_sync <= {phi_sync[SYNC_STAGES-2:0], cpu_clk};
         rwb_sync <= {rwb_sync[SYNC_STAGES-2:0], cpu_rwb};
         phi_d    <= phi_s;
      end
   end

   assign phi_s = phi_sync[SYNC_STAGES-1];
   assign rwb_s = rwb_sync[SYNC_STAGES-1];
   assign rise  = phi_s & ~phi_d;
   assign fall  = ~phi_s & phi_d;

   for (genvar i = 0; i < NUM_CS; i++) begin : g_region
      assign hits[i] = (addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W];
   end

   // Isolate the lowest set bit: lowest-index region has priority.
   assign sel     = hits & (~hits + NUM_CS'(1));
   assign is_bank = (addr == BANK_ADDR);

   assign unused_data = ^data_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_n         <= '1;
         ram_we_n     <= 1'b1;
         bank_oe_n    <= 1'b1;
         bank         <= '0;
         bank_wr_pend <= 1'b0;
         we_cnt       <= '0;
      end else if (rise) begin
         if (is_bank) begin
            bank_oe_n <= ~rwb_s;
            if (!rwb_s) begin
               bank_wr_pend <= 1'b1;
            end
         end else begin
            cs_n <= ~sel;
            if (sel[RAM_IDX] && !rwb_s) begin
               ram_we_n <= 1'b0;
               we_cnt   <= CNT_LOAD;
            end
         end
      end else if (fall) begin
         cs_n      <= '1;
         bank_oe_n <= 1'b1;
         ram_we_n  <= 1'b1;
         we_cnt    <= '0;
         if (bank_wr_pend) begin
            bank         <= data_in[BANK_W-1:0];
            bank_wr_pend <= 1'b0;
         end
      end else if (we_cnt != '0) begin
         we_cnt <= we_cnt - CNT_ONE;
         if (we_cnt == CNT_ONE) begin
            ram_we_n <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_decode.sv
`default_nettype none
// ============================================================================
// tb_mem_decode : randomized phi2 bus cycles against a window-based model of
//                 the decoder, plus directed cycles with literal expectations.
// Revision      : 1.0
// ============================================================================
module tb_mem_decode;

   localparam int          ADDR_W    = 16;
   localparam int          NUM_CS    = 4;
   localparam int          RAM_IDX   = 0;
   localparam int          BANK_W    = 4;
   localparam int          SYNC      = 2;
   localparam int          WE_A      = 2;
   localparam int          WE_B      = 6;
   localparam logic [15:0] BANK_ADDR = 16'hFF00;
   localparam logic [63:0] BASES     = {16'h8000, 16'hD000, 16'hD400, 16'h0000};
   localparam logic [63:0] MASKS     = {16'h8000, 16'hFC00, 16'hFC00, 16'h8000};
   localparam int          NEVER     = 32'h3fff_ffff;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        cpu_clk = 1'b0;
   logic        cpu_rwb = 1'b1;
   logic [15:0] addr    = 16'h0000;
   logic [7:0]  data_in = 8'h00;

   logic [3:0]  cs_a, cs_b, bank_a, bank_b;
   logic        we_a, we_b, oe_a, oe_b;

   mem_decode #(
      .ADDR_W(ADDR_W), .NUM_CS(NUM_CS), .REGION_BASE(BASES), .REGION_MASK(MASKS),
      .RAM_IDX(RAM_IDX), .BANK_ADDR(BANK_ADDR), .BANK_W(BANK_W),
      .WE_CYCLES(WE_A), .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cpu_clk(cpu_clk), .cpu_rwb(cpu_rwb), .addr(addr),
      .data_in(data_in), .cs_n(cs_a), .ram_we_n(we_a), .bank_oe_n(oe_a), .bank(bank_a)
   );

   mem_decode #(
      .ADDR_W(ADDR_W), .NUM_CS(NUM_CS), .REGION_BASE(BASES), .REGION_MASK(MASKS),
      .RAM_IDX(RAM_IDX), .BANK_ADDR(BANK_ADDR), .BANK_W(BANK_W),
      .WE_CYCLES(WE_B), .SYNC_STAGES(SYNC)
   ) dut6 (
      .clk(clk), .rst_n(rst_n), .cpu_clk(cpu_clk), .cpu_rwb(cpu_rwb), .addr(addr),
      .data_in(data_in), .cs_n(cs_b), .ram_we_n(we_b), .bank_oe_n(oe_b), .bank(bank_b)
   );

   always #5 clk = ~clk;

   // One record per phi2 high phase: first clk edge that sees cpu_clk high (r)
   // and low again (f), plus what the CPU presented at the start of the phase.
   typedef struct {
      int          r;
      int          f;
      logic [15:0] a;
      logic        rw;
      logic [7:0]  d;
   } phase_t;

   phase_t      ph[$];
   int          edge_cnt = 0;
   int          checks   = 0;
   int          failures = 0;
   logic [3:0]  exp_bank = 4'h0;
   int          we_lo_a  = 0;
   int          we_lo_b  = 0;
   int          pulses_a = 0;
   int          pulses_b = 0;
   logic        prev_we_a = 1'b1;
   logic        prev_we_b = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int region_of(input logic [15:0] a);
      for (int i = 0; i < NUM_CS; i++) begin
         if ((a & MASKS[i*16 +: 16]) == BASES[i*16 +: 16]) return i;
      end
      return -1;
   endfunction

   task automatic cmp_cycle();
      logic [3:0] ecs;
      logic       eoe, ewa, ewb;
      int         rg;
      ecs = 4'hF; eoe = 1'b1; ewa = 1'b1; ewb = 1'b1;
      if (!rst_n) begin
         exp_bank = 4'h0;
      end else begin
         foreach (ph[k]) begin
            if (ph[k].f + SYNC == edge_cnt && ph[k].a == BANK_ADDR && !ph[k].rw)
               exp_bank = ph[k].d[3:0];
            if (ph[k].r + SYNC <= edge_cnt && edge_cnt < ph[k].f + SYNC) begin
               if (ph[k].a == BANK_ADDR) begin
                  eoe = ~ph[k].rw;
               end else begin
                  rg = region_of(ph[k].a);
                  if (rg >= 0) begin
                     ecs[rg] = 1'b0;
                     if (rg == RAM_IDX && !ph[k].rw) begin
                        ewa = !(edge_cnt < ph[k].r + SYNC + WE_A);
                        ewb = !(edge_cnt < ph[k].r + SYNC + WE_B);
                     end
                  end
               end
            end
         end
      end
      check("cs_n", cs_a, ecs);
      check("cs_n_we6", cs_b, ecs);
      check("ram_we_n", we_a, ewa);
      check("ram_we_n_we6", we_b, ewb);
      check("bank_oe_n", oe_a, eoe);
      check("bank_oe_n_we6", oe_b, eoe);
      check("bank", bank_a, exp_bank);
      check("bank_we6", bank_b, exp_bank);
      if (!we_a) we_lo_a++;
      if (!we_b) we_lo_b++;
      if (prev_we_a && !we_a) pulses_a++;
      if (prev_we_b && !we_b) pulses_b++;
      prev_we_a = we_a;
      prev_we_b = we_b;
   endtask

   always @(posedge clk) begin
      edge_cnt++;
      #1;
      cmp_cycle();
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_phase(input logic [15:0] a, input logic rw, input logic [7:0] d);
      phase_t p;
      @(negedge clk);
      addr = a; cpu_rwb = rw; data_in = d;
      @(negedge clk);
      cpu_clk = 1'b1;
      if (rst_n) begin
         p.r = edge_cnt + 1; p.f = NEVER; p.a = a; p.rw = rw; p.d = d;
         ph.push_back(p);
      end
   endtask

   task automatic end_phase();
      phase_t p;
      cpu_clk = 1'b0;
      if (rst_n && ph.size() > 0) begin
         p = ph.pop_back();
         if (p.f == NEVER) p.f = edge_cnt + 1;
         ph.push_back(p);
      end
   endtask

   // Directed phase with literal expectations at the assert/deassert edges.
   task automatic lit_phase(input logic [15:0] a, input logic rw, input logic [7:0] d,
                            input int hi, input int lo, input logic [3:0] ecs,
                            input logic eoe, input int elo_a, input int elo_b);
      we_lo_a = 0; we_lo_b = 0; pulses_a = 0; pulses_b = 0;
      start_phase(a, rw, d);
      wait_neg(SYNC);
      check("lit_pre_rise_cs", cs_a, 4'hF);
      wait_neg(1);
      check("lit_rise_cs", cs_a, ecs);
      check("lit_rise_cs_we6", cs_b, ecs);
      check("lit_rise_oe", oe_a, eoe);
      wait_neg(hi - SYNC - 1);
      end_phase();
      wait_neg(SYNC);
      check("lit_pre_fall_cs", cs_a, ecs);
      wait_neg(1);
      check("lit_fall_cs", cs_a, 4'hF);
      check("lit_fall_oe", oe_a, 1'b1);
      check("lit_fall_we6", we_b, 1'b1);
      wait_neg(lo - SYNC - 1);
      check("lit_we_low_clks", we_lo_a, elo_a);
      check("lit_we_low_clks_we6", we_lo_b, elo_b);
      check("lit_we_pulses", pulses_a, 32'(elo_a > 0));
      check("lit_we_pulses_we6", pulses_b, 32'(elo_b > 0));
   endtask

   task automatic rand_phase();
      logic [15:0] a;
      int          hi, lo;
      case ($urandom_range(0, 5))
         0: a = BANK_ADDR;
         1: a = 16'($urandom);
         2: a = 16'hD000 | 16'($urandom_range(0, 16'h03FF));
         3: a = 16'hD400 | 16'($urandom_range(0, 16'h03FF));
         4: a = 16'($urandom_range(0, 16'h7FFF));
         default: a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      endcase
      hi = $urandom_range(4, 12);
      lo = $urandom_range(4, 10);
      start_phase(a, 1'($urandom_range(0, 1)), 8'($urandom));
      wait_neg(SYNC + 1);
      // Bus wiggles after the decode point must not matter.
      if ($urandom_range(0, 1) == 1) begin
         addr    = 16'($urandom);
         cpu_rwb = 1'($urandom_range(0, 1));
      end
      wait_neg(hi - SYNC - 1);
      end_phase();
      wait_neg(lo);
   endtask

   initial begin
      // Reset held while phi2 keeps running.
      repeat (4) begin
         wait_neg(4);
         cpu_clk = ~cpu_clk;
      end
      // Release in the middle of a phi2 high phase.
      cpu_clk = 1'b1; addr = 16'h1234; cpu_rwb = 1'b1;
      wait_neg(4);
      rst_n = 1'b1;
      wait_neg(8);
      check("release_high_cs", cs_a, 4'hF);
      cpu_clk = 1'b0;
      wait_neg(6);
      lit_phase(16'h1234, 1'b1, 8'h00, 8, 8, 4'b1110, 1'b1, 0, 0);

      // Read decode across all regions (region 2 = D000/FC00, region 1 = D400/FC00).
      lit_phase(16'h0100, 1'b1, 8'h00, 8, 8, 4'b1110, 1'b1, 0, 0);
      lit_phase(16'hD020, 1'b1, 8'h00, 8, 8, 4'b1011, 1'b1, 0, 0);
      lit_phase(16'hD410, 1'b1, 8'h00, 8, 8, 4'b1101, 1'b1, 0, 0);
      lit_phase(16'hE000, 1'b1, 8'h00, 8, 8, 4'b0111, 1'b1, 0, 0);

      // RAM write: full pulses, then a high phase too short for the long pulse.
      lit_phase(16'h0200, 1'b0, 8'h3C, 8, 8, 4'b1110, 1'b1, WE_A, WE_B);
      lit_phase(16'h0200, 1'b0, 8'h3C, 5, 8, 4'b1110, 1'b1, WE_A, 5);

      // Bank register write then read.
      lit_phase(16'hFF00, 1'b0, 8'hA5, 8, 8, 4'b1111, 1'b1, 0, 0);
      check("bank_after_write", bank_a, 4'h5);
      check("bank_after_write_we6", bank_b, 4'h5);
      lit_phase(16'hFF00, 1'b1, 8'h00, 8, 8, 4'b1111, 1'b0, 0, 0);
      check("bank_after_read", bank_a, 4'h5);

      repeat (150) rand_phase();

      // Asynchronous reset in the middle of a RAM write pulse.
      start_phase(16'h0200, 1'b0, 8'h00);
      wait_neg(SYNC + 1);
      check("pre_reset_we", we_a, 1'b0);
      check("pre_reset_cs", cs_a, 4'b1110);
      #2;
      rst_n = 1'b0;
      ph.delete();
      #1;
      check("async_reset_we", we_a, 1'b1);
      check("async_reset_we6", we_b, 1'b1);
      check("async_reset_cs", cs_a, 4'hF);
      check("async_reset_cs_we6", cs_b, 4'hF);
      check("async_reset_bank", bank_a, 4'h0);
      end_phase();
      wait_neg(4);
      rst_n = 1'b1;
      wait_neg(6);
      lit_phase(16'hD7FF, 1'b1, 8'h00, 8, 8, 4'b1101, 1'b1, 0, 0);
      lit_phase(16'h7FFF, 1'b0, 8'h00, 8, 8, 4'b1110, 1'b1, WE_A, WE_B);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
